// File: rtl/ex_alu_seq.sv
// Execute-stage ALU: single-cycle base integer ops plus iterative RISC-V M-extension
// multiply/divide (one bit per cycle), with valid/ready handshakes on both sides.
module ex_alu_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      ALU_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state_o
);

  // Handshake: an op is taken on a cycle with in_valid & in_ready & !flush;
  // a result is consumed on a cycle with out_valid & out_ready. Both sides hold
  // their payload stable while valid is high and the partner is not ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [4:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     result_q, result_d;

  localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

  // Accept-time decode
  logic            is_m, is_div, sgn_a, sgn_b, sa, sb, b_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag, base_res;
  logic [SHW-1:0]  shamt;

  assign is_m   = (ALU_control[4:3] == 2'b10);
  assign is_div = is_m & ALU_control[2];
  assign sgn_a  = is_div ? ~ALU_control[0]
                         : (ALU_control[1:0] == 2'b01) | (ALU_control[1:0] == 2'b10);
  assign sgn_b  = is_div ? ~ALU_control[0] : (ALU_control[1:0] == 2'b01);
  assign sa     = sgn_a & A[XLEN-1];
  assign sb     = sgn_b & B[XLEN-1];
  assign a_mag  = sa ? -A : A;
  assign b_mag  = sb ? -B : B;
  assign b_zero = (B == '0);
  assign ovf    = ~ALU_control[0] & (A == MIN_S) & (B == '1);
  assign shamt  = B[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (ALU_control)
      5'h00: base_res = A & B;
      5'h01: base_res = A | B;
      5'h02: base_res = A + B;
      5'h03: base_res = A ^ B;
      5'h04: base_res = A << shamt;
      5'h05: base_res = A >> shamt;
      5'h06: base_res = A - B;
      5'h07: base_res = XLEN'($signed(A) < $signed(B));
      5'h08: base_res = XLEN'(A < B);
      5'h09: base_res = XLEN'($signed(A) >>> shamt);
      5'h0A: base_res = A;
      5'h0B: base_res = B;
      default: base_res = '0;
    endcase
  end

  // Iteration datapath: prod_q is {partial product, multiplier} for multiply
  // and {partial remainder, dividend/quotient} for divide.
  logic              op_is_div;
  logic [XLEN:0]     mul_sum, dsh, dtrial;
  logic [2*XLEN-1:0] mul_step, div_step, mul_fix;
  logic [XLEN-1:0]   div_raw, fin_res;

  assign op_is_div = op_q[2];
  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_step  = {mul_sum, prod_q[XLEN-1:1]};
  assign dsh       = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign dtrial    = dsh - {1'b0, mcand_q};
  assign div_step  = dtrial[XLEN] ? {dsh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                  : {dtrial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
  assign mul_fix   = neg_q ? -mul_step : mul_step;
  assign div_raw   = op_q[1] ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];

  always_comb begin
    fin_res = '0;
    if (op_is_div)               fin_res = neg_q ? -div_raw : div_raw;
    else if (op_q[1:0] == 2'b00) fin_res = mul_fix[XLEN-1:0];
    else                         fin_res = mul_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d = ALU_control;
            if (!is_m) begin
              result_d = base_res;
              state_d  = S_DONE;
            end else if (is_div && b_zero) begin
              result_d = ALU_control[1] ? A : '1;
              state_d  = S_DONE;
            end else if (is_div && ovf) begin
              result_d = ALU_control[1] ? '0 : A;
              state_d  = S_DONE;
            end else begin
              state_d = S_BUSY;
              cnt_d   = SHW'(XLEN - 1);
              mcand_d = is_div ? b_mag : a_mag;
              prod_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
              neg_d   = (is_div && ALU_control[1]) ? sa : (sa ^ sb);
            end
          end
        end
        S_BUSY: begin
          prod_d = op_is_div ? div_step : mul_step;
          if (cnt_q == '0) begin
            result_d = fin_res;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - SHW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_alu_seq.sv
// Directed bench for ex_alu_seq: driver issues ops and queues expected results,
// a monitor pops and compares on every output handshake.
module tb_ex_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  logic        v16_in = 1'b0;
  logic        r16_in;
  logic [15:0] a16 = '0, b16 = '0;
  logic [4:0]  op16 = '0;
  logic        v16_out;
  logic [15:0] res16;
  logic [1:0]  st16;

  ex_alu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .ALU_control(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .dbg_state_o(dbg_state)
  );

  ex_alu_seq #(.XLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v16_in), .in_ready(r16_in),
    .A(a16), .B(b16), .ALU_control(op16), .out_valid(v16_out), .out_ready(1'b1),
    .result(res16), .dbg_state_o(st16)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Scoreboard
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  bit          seen = 1'b0;

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 64'(cyc), 64'(exp_cyc_q[0]));
        end
        if (out_ready) begin
          check("result", 64'(result), 64'(exp_q.pop_front()));
          void'(exp_cyc_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Driver
  task automatic wait_in_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat, input bit push);
    wait_in_ready();
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cyc + lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 5'($urandom_range(0, 31));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic issue16(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] exp, input int lat);
    int c;
    int n = 0;
    @(negedge clk);
    v16_in = 1'b1;
    op16 = o;
    a16 = x;
    b16 = y;
    c = cyc;
    @(negedge clk);
    v16_in = 1'b0;
    while (!v16_out && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("x16_latency", 64'(cyc - c), 64'(lat));
    check("x16_result", 64'(res16), 64'(exp));
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Base ops, 1-cycle
    issue(5'h02, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1, 1);
    issue(5'h09, 32'h8000_0000, 32'h21,        32'hC000_0000, 1, 1);
    issue(5'h07, 32'hFFFF_FFFF, 32'h1,         32'h1,         1, 1);
    issue(5'h08, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 1);
    issue(5'h06, 32'h5,         32'h7,         32'hFFFF_FFFE, 1, 1);
    issue(5'h03, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 1);
    issue(5'h04, 32'h1,         32'h1F,        32'h8000_0000, 1, 1);
    issue(5'h05, 32'h8000_0000, 32'h4,         32'h0800_0000, 1, 1);
    issue(5'h00, 32'hC,         32'hA,         32'h8,         1, 1);
    issue(5'h01, 32'hC,         32'hA,         32'hE,         1, 1);
    issue(5'h0A, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 1, 1);
    issue(5'h0B, 32'h1234_5678, 32'h9ABC_DEF0, 32'h9ABC_DEF0, 1, 1);
    issue(5'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1, 1);

    // Multiply / divide, iterative
    issue(5'h11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1);
    issue(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1);
    issue(5'h10, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB, 33, 1);
    issue(5'h12, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33, 1);
    issue(5'h14, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33, 1);
    issue(5'h16, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33, 1);
    issue(5'h14, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1);
    issue(5'h17, 32'd100,       32'd7,         32'd2,         33, 1);

    // Special cases, 1-cycle
    issue(5'h15, 32'h7,         32'h0,         32'hFFFF_FFFF, 1, 1);
    issue(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 1);
    issue(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    issue(5'h17, 32'h5,         32'h0,         32'h5,         1, 1);
    drain();

    // Backpressure
    out_ready = 1'b0;
    issue(5'h15, 32'd100, 32'd7, 32'd14, 33, 1);
    for (int n = 0; n < 60 && !out_valid; n++) @(negedge clk);
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_result_stable", 64'(result), 64'd14);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_after", 64'(in_ready), 64'd1);
    drain();

    // Flush mid-MULHU, then a following ADD
    issue(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (40) @(negedge clk);
    issue(5'h02, 32'd2, 32'd3, 32'd5, 1, 1);
    drain();

    // Flush with in_valid in IDLE: op must not be taken
    wait_in_ready();
    flush = 1'b1;
    in_valid = 1'b1;
    op = 5'h02;
    a = 32'd1;
    b = 32'd1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_idle_state", 64'(dbg_state), 64'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-DIV
    issue(5'h14, 32'hFFFF_FFF9, 32'h2, 32'h0, 33, 0);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_no_result", 64'(out_valid), 64'd0);

    // XLEN=16 instance
    issue16(5'h14, 16'h8000, 16'hFFFF, 16'h8000, 1);
    issue16(5'h15, 16'hFFFF, 16'h0003, 16'h5555, 17);
    issue16(5'h11, 16'hFFFE, 16'h0003, 16'hFFFF, 17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_alu_seq.md
# ex_alu_seq

Parametrised, multi-cycle execute-stage ALU that extends the base single-cycle integer ALU operation set with the RISC-V M-extension multiply/divide/remainder operations. It sits in the EX stage of each core and uses valid/ready handshakes on both sides, so the pipeline can stall on long-latency operations. Base operations finish in one registered cycle. Multiply and divide run iteratively, one bit per cycle.

## Interface
- XLEN, 32, datapath width; power of two, 8..64
- SHW, $clog2(XLEN), shift-amount width (derived; not overridable)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of the in-flight or completed op
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an op
- A  input  XLEN  operand A (rs1)
- B  input  XLEN  operand B (rs2/imm)
- ALU_control  input  5  opcode, see Operation
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result

## Operation
- Base opcodes, 1-cycle:
  - 0x00 AND; 0x01 OR; 0x02 ADD; 0x03 XOR
  - 0x04 SLL; 0x05 SRL; 0x06 SUB
  - 0x07 SLT (signed); 0x08 SLTU; 0x09 SRA
  - 0x0A PASS A; 0x0B PASS B
  - Shifts use B[SHW-1:0]; SLT/SLTU produce 0 or 1, zero-extended.
- M opcodes, iterative:
  - 0x10 MUL, low XLEN bits
  - 0x11 MULH (s×s), 0x12 MULHSU (s×u), 0x13 MULHU (u×u); high XLEN bits
  - 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU
- Any other opcode completes in 1 cycle with result 0.
- Multiply: operands converted to magnitude and sign at accept. XLEN-cycle shift-add into a 2·XLEN product. Two's-complement fix-up applied on the final cycle.
- Divide: restoring algorithm on magnitudes, XLEN cycles. Quotient sign = sign(A)^sign(B). Remainder sign = sign(A).
- Special cases are detected at accept and complete in 1 cycle with no iteration:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give A.
  - Signed overflow (A = min signed, B = −1): DIV gives A; REM gives 0.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch operands. Go to DONE for 1-cycle ops, otherwise to BUSY with the iteration counter set to XLEN−1.
  - BUSY: in_ready=0. Counter decrements each cycle. At 0, write result and go to DONE.
  - DONE: out_valid=1 and result held stable. On out_ready, go to IDLE.
- flush forces IDLE next cycle from any state, and out_valid drops. flush with in_valid in IDLE: the op is not accepted. flush has priority over all other events.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, internal operand registers=0.
- Accept cycle = in_valid & in_ready.
- 1-cycle op accepted at cycle t: out_valid at t+1.
- Mul/div accepted at cycle t: out_valid at t+XLEN+1 (t+33 for XLEN=32).
- No new accept while BUSY or DONE. The DONE→IDLE transition costs one cycle, so peak throughput is one op per 2 cycles.
- out_valid held until out_ready. result must not change while out_valid=1 and out_ready=0.
- Reset mid-operation aborts immediately and restores reset values. No partial result appears after reset release.
- Inputs are sampled only on the accept cycle. Changes to A/B/ALU_control afterwards have no effect.

## Test plan
- ADD 0x7FFFFFFF+1 -> 0x80000000 at t+1. SRA 0x80000000 by B=0x21 (amount 1) -> 0xC0000000. SLT −1<1 -> 1. SLTU 0xFFFFFFFF<1 -> 0.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MUL −3×7 -> 0xFFFFFFEB. Each has out_valid exactly 33 cycles after accept.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF at t+1; REM 0x80000000/−1 -> 0 at t+1.
- Backpressure: hold out_ready=0 for 10 cycles after DIVU 100/7 -> result 14 stays stable, in_ready=0, then release -> in_ready=1 one cycle later.
- Assert flush at cycle 10 of a MULHU -> out_valid never rises, in_ready=1 next cycle. A following ADD 2+3 -> 5.
- Drop rst_n asynchronously mid-DIV -> all outputs at reset values immediately. With XLEN=16, DIV 0x8000/0xFFFF -> 0x8000.
